// File: rtl/coinc_window_pkg.sv
// Shared types and header layout for the coincidence window builder.
// The header packs a marker, overflow flag, hit count and the event's first timestamp.
package coinc_window_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HEADER  = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    localparam logic [1:0] HDR_MARKER       = 2'b10;
    localparam int         HDR_MARKER_WIDTH = 2;
    // Overflow bit sits just below the marker: DATA_WIDTH-1-2.
    localparam int         HDR_OVF_FROM_MSB = 2;
    // Count field starts at bit TS_WIDTH, directly above the t0 field.
    localparam int         HDR_CNT_WIDTH    = 8;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/coinc_hit_buffer.sv
// Hit storage for one open event: single write port, registered read port.
// The read address is sampled every cycle so the builder can prefetch slot 0 ahead of DRAIN.
module coinc_hit_buffer
    import coinc_window_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HITS   = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [MAX_HITS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/coinc_window_builder.sv
// Groups time-ordered hits that fall within WINDOW ticks of an event's first hit
// and writes events meeting the multiplicity threshold as header + hits records.
module coinc_window_builder
    import coinc_window_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TS_WIDTH       = 16,
    parameter int WINDOW         = 8,
    parameter int MAX_HITS       = 16,
    parameter int MULT_THRESHOLD = 2,
    parameter int IDLE_TIMEOUT   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rdfifo_data_i,
    input  logic                  rdfifo_empty_i,
    output logic                  rdfifo_rden_o,
    output logic [DATA_WIDTH-1:0] wrfifo_data_o,
    output logic                  wrfifo_wren_o,
    input  logic                  wrfifo_prog_full_i,
    output logic [15:0]           event_count_o,
    output logic [15:0]           drop_count_o,
    output logic [15:0]           overflow_count_o,
    output logic [1:0]            debug_state
);

    localparam int AW = (MAX_HITS > 1) ? $clog2(MAX_HITS) : 1;
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [7:0]          MAX_CNT   = 8'(MAX_HITS);
    localparam logic [7:0]          THRESHOLD = 8'(MULT_THRESHOLD);
    localparam logic [TS_WIDTH-1:0] WIN       = TS_WIDTH'(WINDOW);
    localparam logic [IW-1:0]       IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

    state_t                state;
    logic                  rd_valid;
    logic [TS_WIDTH-1:0]   t0;
    logic [7:0]            cnt;
    logic                  ovf;
    logic                  pend_valid;
    logic [DATA_WIDTH-1:0] pend_word;
    logic [IW-1:0]         idle_cnt;
    logic [7:0]            drain_idx;

    logic [TS_WIDTH-1:0]   hit_ts;
    logic [TS_WIDTH-1:0]   pend_ts;
    logic [TS_WIDTH-1:0]   delta;
    logic                  in_window;
    logic                  timeout_now;
    logic                  close_now;
    logic                  keep_event;
    logic                  drain_step;
    logic                  drain_last;
    logic                  buf_wr_en;
    logic [AW-1:0]         buf_wr_addr;
    logic [AW-1:0]         buf_rd_addr;
    logic [DATA_WIDTH-1:0] buf_wr_data;
    logic [DATA_WIDTH-1:0] buf_rd_data;
    logic [DATA_WIDTH-1:0] header_word;

    assign hit_ts      = rdfifo_data_i[DATA_WIDTH-1 -: TS_WIDTH];
    assign pend_ts     = pend_word[DATA_WIDTH-1 -: TS_WIDTH];
    // Modular difference keeps events that straddle timestamp wrap together.
    assign delta       = hit_ts - t0;
    assign in_window   = delta < WIN;
    assign timeout_now = (state == ST_COLLECT) && !rd_valid && (idle_cnt == IDLE_LAST);
    assign close_now   = (state == ST_COLLECT) && ((rd_valid && !in_window) || timeout_now);
    assign keep_event  = cnt >= THRESHOLD;
    assign drain_step  = (state == ST_DRAIN) && !wrfifo_prog_full_i;
    assign drain_last  = drain_idx == (cnt - 8'd1);
    assign debug_state = state;

    // Reads stop on the closing cycle so nothing is in flight once COLLECT is left.
    assign rdfifo_rden_o = !rst && !rdfifo_empty_i && !close_now &&
                           ((state == ST_IDLE) || (state == ST_COLLECT));

    always_comb begin
        buf_wr_en   = 1'b0;
        buf_wr_addr = '0;
        buf_wr_data = rdfifo_data_i;
        if (rd_valid && (state == ST_IDLE)) begin
            buf_wr_en = 1'b1;
        end else if (rd_valid && (state == ST_COLLECT)) begin
            if (in_window) begin
                buf_wr_en   = cnt < MAX_CNT;
                buf_wr_addr = AW'(cnt);
            end else begin
                buf_wr_en = !keep_event;
            end
        end else if (drain_step && drain_last && pend_valid) begin
            buf_wr_en   = 1'b1;
            buf_wr_data = pend_word;
        end
    end

    always_comb begin
        buf_rd_addr = '0;
        if (state == ST_DRAIN) begin
            if (!drain_step) begin
                buf_rd_addr = AW'(drain_idx);
            end else if (!drain_last) begin
                buf_rd_addr = AW'(drain_idx + 8'd1);
            end
        end
    end

    always_comb begin
        header_word = '0;
        header_word[DATA_WIDTH-1 -: HDR_MARKER_WIDTH]   = HDR_MARKER;
        header_word[DATA_WIDTH-1-HDR_OVF_FROM_MSB]      = ovf;
        header_word[TS_WIDTH +: HDR_CNT_WIDTH]          = cnt;
        header_word[TS_WIDTH-1:0]                       = t0;
    end

    coinc_hit_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_HITS   (MAX_HITS),
        .ADDR_WIDTH (AW)
    ) u_hit_buffer (
        .clk     (clk),
        .wr_en   (buf_wr_en),
        .wr_addr (buf_wr_addr),
        .wr_data (buf_wr_data),
        .rd_addr (buf_rd_addr),
        .rd_data (buf_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            rd_valid         <= 1'b0;
            t0               <= '0;
            cnt              <= '0;
            ovf              <= 1'b0;
            pend_valid       <= 1'b0;
            pend_word        <= '0;
            idle_cnt         <= '0;
            drain_idx        <= '0;
            wrfifo_data_o    <= '0;
            wrfifo_wren_o    <= 1'b0;
            event_count_o    <= '0;
            drop_count_o     <= '0;
            overflow_count_o <= '0;
        end else begin
            rd_valid      <= rdfifo_rden_o && !rdfifo_empty_i;
            wrfifo_wren_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_valid) begin
                        t0       <= hit_ts;
                        cnt      <= 8'd1;
                        ovf      <= 1'b0;
                        idle_cnt <= '0;
                        state    <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (rd_valid) begin
                        idle_cnt <= '0;
                        if (in_window) begin
                            if (cnt < MAX_CNT) begin
                                cnt <= cnt + 8'd1;
                            end else begin
                                ovf              <= 1'b1;
                                overflow_count_o <= sat_inc(overflow_count_o);
                            end
                        end else if (keep_event) begin
                            pend_valid <= 1'b1;
                            pend_word  <= rdfifo_data_i;
                            drain_idx  <= '0;
                            state      <= ST_HEADER;
                        end else begin
                            // Dropped event: the outside hit opens the next one immediately.
                            drop_count_o <= sat_inc(drop_count_o);
                            t0           <= hit_ts;
                            cnt          <= 8'd1;
                            ovf          <= 1'b0;
                        end
                    end else if (timeout_now) begin
                        idle_cnt <= '0;
                        if (keep_event) begin
                            drain_idx <= '0;
                            state     <= ST_HEADER;
                        end else begin
                            drop_count_o <= sat_inc(drop_count_o);
                            cnt          <= '0;
                            ovf          <= 1'b0;
                            state        <= ST_IDLE;
                        end
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                ST_HEADER: begin
                    if (!wrfifo_prog_full_i) begin
                        wrfifo_wren_o <= 1'b1;
                        wrfifo_data_o <= header_word;
                        state         <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_step) begin
                        wrfifo_wren_o <= 1'b1;
                        wrfifo_data_o <= buf_rd_data;
                        if (drain_last) begin
                            event_count_o <= sat_inc(event_count_o);
                            drain_idx     <= '0;
                            ovf           <= 1'b0;
                            if (pend_valid) begin
                                t0         <= pend_ts;
                                cnt        <= 8'd1;
                                pend_valid <= 1'b0;
                                idle_cnt   <= '0;
                                state      <= ST_COLLECT;
                            end else begin
                                cnt   <= '0;
                                state <= ST_IDLE;
                            end
                        end else begin
                            drain_idx <= drain_idx + 8'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coinc_window_builder.sv
// Randomized and directed bench for coinc_window_builder with a queue-based
// reference model of event grouping and a monitor that checks every record word.
module tb_coinc_window_builder;

    localparam int DW           = 32;
    localparam int TW           = 16;
    localparam int WINDOW       = 8;
    localparam int MAX_HITS     = 16;
    localparam int THR          = 2;
    localparam int IDLE_TIMEOUT = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] rdfifo_data = '0;
    logic          rdfifo_empty = 1'b1;
    logic          rdfifo_rden;
    logic [DW-1:0] wrfifo_data;
    logic          wrfifo_wren;
    logic          wrfifo_prog_full;
    logic [15:0]   event_count;
    logic [15:0]   drop_count;
    logic [15:0]   overflow_count;
    logic [1:0]    debug_state;

    logic [DW-1:0] hit_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] burst_q[$];
    logic [DW-1:0] grp[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            words_seen = 0;
    logic [15:0]   m_events = '0;
    logic [15:0]   m_drops = '0;
    logic [15:0]   m_ovf = '0;
    logic          rand_pf_en = 1'b0;
    logic          pf_force = 1'b0;

    always #5 clk = ~clk;

    coinc_window_builder #(
        .DATA_WIDTH     (DW),
        .TS_WIDTH       (TW),
        .WINDOW         (WINDOW),
        .MAX_HITS       (MAX_HITS),
        .MULT_THRESHOLD (THR),
        .IDLE_TIMEOUT   (IDLE_TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rdfifo_data_i      (rdfifo_data),
        .rdfifo_empty_i     (rdfifo_empty),
        .rdfifo_rden_o      (rdfifo_rden),
        .wrfifo_data_o      (wrfifo_data),
        .wrfifo_wren_o      (wrfifo_wren),
        .wrfifo_prog_full_i (wrfifo_prog_full),
        .event_count_o      (event_count),
        .drop_count_o       (drop_count),
        .overflow_count_o   (overflow_count),
        .debug_state        (debug_state)
    );

    // Sorted-hit FIFO: word appears the cycle after a read, empty tracks occupancy.
    always @(posedge clk) begin
        if (rdfifo_rden && !rdfifo_empty) rdfifo_data <= hit_q.pop_front();
        rdfifo_empty <= (hit_q.size() == 0);
    end

    initial begin
        wrfifo_prog_full = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            wrfifo_prog_full = rand_pf_en ? ($urandom_range(0, 3) == 0) : pf_force;
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every written word must be the next expected record word.
    initial begin
        forever begin
            @(negedge clk);
            if (wrfifo_wren === 1'b1) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h expected no write", wrfifo_data);
                end else begin
                    check("record_word", wrfifo_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic close_group(input logic [TW-1:0] t0);
        int n;
        int k;
        logic [DW-1:0] hdr;
        n = grp.size();
        k = (n > MAX_HITS) ? MAX_HITS : n;
        if (n >= THR) begin
            hdr = '0;
            hdr[DW-1:DW-2] = 2'b10;
            hdr[DW-3] = (n > MAX_HITS);
            hdr[TW+7:TW] = 8'(k);
            hdr[TW-1:0] = t0;
            exp_q.push_back(hdr);
            for (int i = 0; i < k; i++) exp_q.push_back(grp[i]);
            m_events = m_events + 16'd1;
        end else begin
            m_drops = m_drops + 16'd1;
        end
        if (n > MAX_HITS) m_ovf = m_ovf + 16'(n - MAX_HITS);
        grp.delete();
    endtask

    // Groups the burst by the window rule, queues expected records, then feeds the FIFO.
    task automatic issue_burst();
        logic [TW-1:0] t0;
        logic [TW-1:0] ts;
        logic [TW-1:0] d;
        t0 = '0;
        for (int i = 0; i < burst_q.size(); i++) begin
            ts = burst_q[i][DW-1 -: TW];
            d  = ts - t0;
            if (grp.size() == 0) begin
                t0 = ts;
                grp.push_back(burst_q[i]);
            end else if (d < TW'(WINDOW)) begin
                grp.push_back(burst_q[i]);
            end else begin
                close_group(t0);
                t0 = ts;
                grp.push_back(burst_q[i]);
            end
        end
        if (grp.size() != 0) close_group(t0);
        @(negedge clk);
        foreach (burst_q[i]) hit_q.push_back(burst_q[i]);
        burst_q.delete();
    endtask

    task automatic add_hit(input logic [TW-1:0] ts);
        burst_q.push_back({ts, 16'($urandom)});
    endtask

    task automatic wait_quiet();
        int budget;
        budget = 3000;
        while ((hit_q.size() != 0 || exp_q.size() != 0) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d words still expected, required 0", exp_q.size());
            exp_q.delete();
            hit_q.delete();
        end
        repeat (IDLE_TIMEOUT + 8) @(posedge clk);
    endtask

    task automatic wait_words(input int target);
        int budget;
        budget = 1000;
        while (words_seen < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_words: saw %0d words, required %0d", words_seen, target);
        end
        #1;
    endtask

    task automatic check_counters();
        check("event_count", DW'(event_count), DW'(m_events));
        check("drop_count", DW'(drop_count), DW'(m_drops));
        check("overflow_count", DW'(overflow_count), DW'(m_ovf));
    endtask

    initial begin
        logic [TW-1:0] ts;
        int base;
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wren", DW'(wrfifo_wren), '0);
        check("rst_data", wrfifo_data, '0);
        check("rst_state", DW'(debug_state), '0);
        check_counters();
        rst = 1'b0;
        #1;
        check("rst_rden", DW'(rdfifo_rden), '0);

        // Window grouping with a trailing lone hit that times out and is dropped.
        add_hit(16'd100); add_hit(16'd103); add_hit(16'd107); add_hit(16'd120);
        issue_burst(); wait_quiet(); check_counters();

        // Event straddling timestamp wrap.
        add_hit(16'hFFFE); add_hit(16'h0003);
        issue_burst(); wait_quiet(); check_counters();

        // Delta equal to WINDOW starts a new event.
        add_hit(16'd200); add_hit(16'd201); add_hit(16'd208); add_hit(16'd209);
        issue_burst(); wait_quiet(); check_counters();

        // Buffer overflow.
        for (int i = 0; i < 20; i++) add_hit(16'd50);
        issue_burst(); wait_quiet(); check_counters();

        // Back-pressure in the middle of a drain.
        base = words_seen;
        for (int i = 0; i < 10; i++) add_hit(16'(300 + (i % 4)));
        issue_burst();
        wait_words(base + 3);
        pf_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_wren", DW'(wrfifo_wren), '0);
        end
        pf_force = 1'b0;
        wait_quiet(); check_counters();

        // Reset in the middle of a drain.
        base = words_seen;
        for (int i = 0; i < 12; i++) add_hit(16'd400);
        issue_burst();
        wait_words(base + 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_events = '0; m_drops = '0; m_ovf = '0;
        #1;
        check("mid_rst_wren", DW'(wrfifo_wren), '0);
        check("mid_rst_rden", DW'(rdfifo_rden), '0);
        check_counters();
        add_hit(16'd500); add_hit(16'd505); add_hit(16'd506);
        issue_burst(); wait_quiet(); check_counters();

        // Randomized bursts, half of them under random back-pressure.
        for (int it = 0; it < 24; it++) begin
            rand_pf_en = it[0];
            ts = 16'($urandom);
            n = $urandom_range(1, 22);
            for (int i = 0; i < n; i++) begin
                add_hit(ts);
                if ($urandom_range(0, 5) == 0) ts = ts + 16'($urandom_range(0, 20));
                else ts = ts + 16'($urandom_range(0, 3));
            end
            issue_burst(); wait_quiet(); check_counters();
        end
        rand_pf_en = 1'b0;
        repeat (4) @(posedge clk);
        check("exp_queue_left", DW'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coinc_window_builder.md
# coinc_window_builder

Downstream of the channel sorter: reads the time-ordered hit stream from the sorter's output FIFO and groups hits whose timestamps fall within a fixed window of the event's first hit. Each group is written as one event record, a header word followed by its hits, into the event FIFO. Events below a multiplicity threshold are discarded. This stage is the multiplicity trigger of the consolidation chain.

## Interface
- DATA_WIDTH, 32, hit/record word width; must be ≥ TS_WIDTH+11
- TS_WIDTH, 16, timestamp width; hit timestamp = data[DATA_WIDTH-1 -: TS_WIDTH]
- WINDOW, 8, window length in timestamp ticks
- MAX_HITS, 16, hit buffer depth, ≤255
- MULT_THRESHOLD, 2, minimum hits for an event to be written
- IDLE_TIMEOUT, 32, cycles without input before an open event closes
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdfifo_data_i  in  DATA_WIDTH  sorted hit word; valid the cycle after rden
- rdfifo_empty_i  in  1  sorted FIFO empty
- rdfifo_rden_o  out  1  sorted FIFO read enable
- wrfifo_data_o  out  DATA_WIDTH  event record word, registered
- wrfifo_wren_o  out  1  event record word valid, registered
- wrfifo_prog_full_i  in  1  event FIFO programmable full
- event_count_o  out  16  events written, saturating
- drop_count_o  out  16  events discarded below threshold, saturating
- overflow_count_o  out  16  hits discarded because the buffer was full, saturating

## Operation
- rd_valid register: set to rden & ~empty of the previous cycle.
- Δ = (ts − t0) mod 2^TS_WIDTH. A hit is in the window iff Δ < WINDOW, so timestamp wrap is handled.
- FSM states: IDLE, COLLECT, HEADER, DRAIN.
- IDLE, on rd_valid:
  - t0 ← ts; buf[0] ← word; cnt ← 1; go to COLLECT.
- COLLECT, on rd_valid with hit in window:
  - If cnt < MAX_HITS: buf[cnt] ← word; cnt++.
  - Otherwise: discard the hit; set ovf; overflow_count++.
- COLLECT, on rd_valid with hit outside window:
  - Latch the word as pending; close the event.
- COLLECT, idle counter:
  - Counts cycles without rd_valid; cleared on every rd_valid.
  - Reaching IDLE_TIMEOUT closes the event with no pending word.
- Close:
  - If cnt ≥ MULT_THRESHOLD: go to HEADER.
  - Otherwise: drop_count++; skip output.
- HEADER:
  - Writes the header when ~prog_full.
  - Header fields: [DATA_WIDTH-1:DATA_WIDTH-2] = 2'b10; [DATA_WIDTH-3] = ovf; [TS_WIDTH+7:TS_WIDTH] = cnt; [TS_WIDTH-1:0] = t0; all other bits 0.
- DRAIN:
  - Writes buf[0..cnt−1] in order, one per cycle while ~prog_full; event_count++ after the last hit.
- After DRAIN, or after a skipped output:
  - If a word is pending: it becomes the first hit of a new event (t0, buf[0], cnt = 1, ovf = 0); go to COLLECT.
  - Otherwise: go to IDLE.
- rdfifo_rden_o is combinational: ~empty & (IDLE|COLLECT) & ~close_now.
  - close_now = rd_valid & outside window, or the timeout condition this cycle.
  - This guarantees no read is in flight when leaving COLLECT.

## Timing
- Reset values: rden 0, wren 0, data 0, all counters 0, state IDLE, cnt 0, ovf 0, pending cleared.
- A reset mid-event discards buffered and pending hits and produces no partial record.
- Input throughput: one hit per cycle in IDLE/COLLECT. No reads occur in HEADER/DRAIN.
- Close at cycle c: header wren at c+2 at the earliest; hits follow back-to-back.
- wrfifo_prog_full_i sampled high: no wren the next cycle, and the record position is held.
  - On release, output resumes with the same word: no loss or duplication.
- Simultaneous rd_valid and idle counter reaching IDLE_TIMEOUT: the hit wins and the counter clears.
- Counters saturate at 0xFFFF.

## Structure
- Package coinc_window_pkg holds:
  - the state enum;
  - the header marker 2'b10;
  - header field offset constants.
- Sub-module coinc_hit_buffer: MAX_HITS×DATA_WIDTH storage with one write port and a synchronous read port.
  - In HEADER the builder pre-issues address 0, so DRAIN runs at one word per cycle.

## Test plan
- Hits at ts 100, 103, 107, 120, then idle → header t0=100 cnt=3 plus 3 hits; 120 times out alone (cnt=1) → drop_count=1, event_count=1.
- Hits at ts 0xFFFE, 0x0003, then idle → one event, t0=0xFFFE cnt=2 (Δ=5).
- Hits at ts 200, 201, 208, 209 → two events, cnt=2 each; 208 is outside (Δ=WINDOW).
- 20 hits at ts=50 → header cnt=16 ovf=1, 16 hits written, overflow_count=4.
- prog_full high for 5 cycles mid-DRAIN → no wren during that time; on release the record continues, and the full sequence matches the expected sequence.
- rst asserted during DRAIN → next cycle wren=0, rden=0, counters=0; the following event's record is complete and correct.
